// File: rtl/alu_dec_stage.sv
// Decode stage for the logical-op subset of MIPS: decodes each accepted word
// into ALU controls and holds up to two entries in a main/skid buffer pair.
//
// state | meaning
// EMPTY | no entries held, outputs idle
// ONE   | main register holds the entry on the outputs
// FULL  | main and skid both hold entries, input stalled
module alu_dec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic [4:0]  wr_reg,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_XOR = 5'b00010;
  localparam logic [4:0] OP_NOR = 5'b00011;
  localparam logic [4:0] OP_LUI = 5'b00100;
  localparam logic [4:0] OP_NOP = 5'b11111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm_ext;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{OP_NOP, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0};

  state_t state, next_state;
  entry_t main_q, skid_q, dec;
  logic   accept, consume;
  logic   load_main, load_skid, main_from_skid;

  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       unused_rs;

  assign op        = instr[31:26];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign funct     = instr[5:0];
  assign unused_rs = ^instr[25:21];

  always_comb begin
    dec             = ENTRY_RST;
    dec.imm_ext     = {16'b0, instr[15:0]};
    dec.illegal     = 1'b1;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100100: dec.alu_op = OP_AND;
          6'b100101: dec.alu_op = OP_OR;
          6'b100110: dec.alu_op = OP_XOR;
          6'b100111: dec.alu_op = OP_NOR;
          default:   dec.alu_op = OP_NOP;
        endcase
        if (dec.alu_op != OP_NOP) begin
          dec.wr_reg    = rd;
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        case (op[1:0])
          2'b00:   dec.alu_op = OP_AND;
          2'b01:   dec.alu_op = OP_OR;
          2'b10:   dec.alu_op = OP_XOR;
          default: dec.alu_op = OP_LUI;
        endcase
        dec.alu_src_imm = 1'b1;
        dec.wr_reg      = rt;
        dec.reg_write   = 1'b1;
        dec.illegal     = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (consume) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          next_state     = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush drops everything, including the word presented this cycle.
    if (flush) begin
      next_state     = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= ENTRY_RST;
      skid_q <= ENTRY_RST;
    end else begin
      state <= next_state;
      if (load_main)
        main_q <= dec;
      else if (main_from_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= dec;
    end
  end

  assign alu_op      = main_q.alu_op;
  assign alu_src_imm = main_q.alu_src_imm;
  assign imm_ext     = main_q.imm_ext;
  assign wr_reg      = main_q.wr_reg;
  assign reg_write   = main_q.reg_write;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_dec_stage.sv
// Bench for alu_dec_stage: a queue model of the 2-deep buffer plus a table
// decoder, checked every cycle, with directed literal cases and random traffic.
module tb_alu_dec_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid;
  logic [4:0]  alu_op, wr_reg;
  logic        alu_src_imm, reg_write, illegal;
  logic [31:0] imm_ext;

  alu_dec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .imm_ext(imm_ext), .wr_reg(wr_reg),
    .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  function automatic exp_t ref_dec(logic [31:0] w);
    exp_t e;
    logic [5:0] o, f;
    o = w[31:26];
    f = w[5:0];
    e.op = 5'b11111; e.src = 1'b0; e.imm = {16'h0, w[15:0]};
    e.wr = 5'd0; e.rw = 1'b0; e.ill = 1'b1;
    if (o == 6'd0 && f >= 6'h24 && f <= 6'h27) begin
      e.op = 5'(f - 6'h24); e.wr = w[15:11]; e.rw = 1'b1; e.ill = 1'b0;
    end else if (o >= 6'h0C && o <= 6'h0F) begin
      e.op = (o == 6'h0F) ? 5'b00100 : 5'(o - 6'h0C);
      e.src = 1'b1; e.wr = w[20:16]; e.rw = 1'b1; e.ill = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of buffer occupancy and contents.
  always @(posedge clk) begin
    logic acc, cons;
    acc  = in_valid && (q.size() < 2);
    cons = (q.size() > 0) && out_ready;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(instr));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      if (q.size() != 0) begin
        chk("alu_op", {27'b0, alu_op}, {27'b0, q[0].op});
        chk("alu_src_imm", {31'b0, alu_src_imm}, {31'b0, q[0].src});
        chk("imm_ext", imm_ext, q[0].imm);
        chk("wr_reg", {27'b0, wr_reg}, {27'b0, q[0].wr});
        chk("reg_write", {31'b0, reg_write}, {31'b0, q[0].rw});
        chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
      end
    end
  end

  task automatic step(input logic iv, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic r);
    in_valid = iv; instr = w; out_ready = ordy; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return {6'b0, r[25:6], 6'(6'h24 + $urandom_range(0, 3))};
      1: return {6'(6'h0C + $urandom_range(0, 3)), r[25:0]};
      2: return {6'b0, r[25:0]};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] I_AND = 32'h00851824;
  localparam logic [31:0] I_LUI = 32'h3C0A1234;
  localparam logic [31:0] I_ADD = 32'h00851820;
  localparam logic [31:0] I_OR  = 32'h00851825;
  localparam logic [31:0] I_XRI = 32'h38C700FF;

  initial begin
    int sent, recv;
    logic ordy, acc, cons;
    in_valid = 0; instr = 0; out_ready = 0; flush = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0);

    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_op", {27'b0, alu_op}, 32'h1F);
    chk("rst_fields", {imm_ext[31:0]}, 32'd0);
    chk("rst_flags", {24'b0, wr_reg, alu_src_imm, reg_write, illegal}, 32'd0);

    step(1, I_AND, 1, 0, 0);
    chk("and_valid", {31'b0, out_valid}, 32'd1);
    chk("and_dec", {24'b0, alu_op, alu_src_imm, reg_write, illegal}, {24'b0, 5'b00000, 3'b010});
    chk("and_wr", {27'b0, wr_reg}, 32'd3);

    step(1, I_LUI, 1, 0, 0);
    chk("lui_dec", {24'b0, alu_op, alu_src_imm, reg_write, illegal}, {24'b0, 5'b00100, 3'b110});
    chk("lui_imm", imm_ext, 32'h00001234);
    chk("lui_wr", {27'b0, wr_reg}, 32'd10);

    step(1, I_ADD, 1, 0, 0);
    chk("add_dec", {24'b0, alu_op, alu_src_imm, reg_write, illegal}, {24'b0, 5'b11111, 3'b001});
    step(0, 0, 1, 0, 0);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Stall: push A then B with no downstream ready.
    step(1, I_OR, 0, 0, 0);
    step(1, I_XRI, 0, 0, 0);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_hold_a", {27'b0, alu_op}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("stall_hold_a_wr", {27'b0, wr_reg}, 32'd3);
    step(0, 0, 1, 0, 0);
    chk("b_after_a", {27'b0, wr_reg}, 32'd7);
    chk("b_op", {27'b0, alu_op}, 32'd2);
    chk("ready_after_a", {31'b0, in_ready}, 32'd1);
    step(0, 0, 1, 0, 0);
    chk("b_consumed", {31'b0, out_valid}, 32'd0);

    // Flush while FULL with a new word presented.
    step(1, I_OR, 0, 0, 0);
    step(1, I_XRI, 0, 0, 0);
    step(1, I_LUI, 0, 1, 0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    step(0, 0, 1, 0, 0);
    chk("flush_stays_empty", {31'b0, out_valid}, 32'd0);

    // Eight ori words with out_ready toggling.
    sent = 0; recv = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      ordy = c[0];
      acc  = (sent < 8) && in_ready;
      cons = out_valid && ordy;
      if (cons) begin
        chk("ori_order", {27'b0, wr_reg}, 32'(recv + 1));
        chk("ori_imm", imm_ext, 32'(recv * 32'h111));
        recv++;
      end
      step(sent < 8, {6'b001101, 5'd2, 5'(sent + 1), 16'(sent * 16'h111)}, ordy, 0, 0);
      if (acc) sent++;
    end
    chk("ori_count", 32'(recv), 32'd8);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
